rxll_frame_rd: RTL and testbench
================================

Name: rxll_frame_rd

Overview:
- Parametrised read-side controller for the SATA link-layer RX FIFO; successor to the plain pass-through RX FIFO read wrapper.
- Pulls words from a standard (non-FWFT, 1-cycle read latency) FIFO holding {sof, eof, 2 reserved, data}.
- Presents them on a valid/ready stream through a 2-entry prefetch buffer at 1 word/cycle.
- Enforces frame structure (SOF/EOF pairing, maximum length), truncates bad frames and keeps frame and error statistics.

Parameters:
C_DW, 32, data width in bits
C_LW, 12, frame word-length counter width
C_MAX_WORDS, 2049, maximum words per frame including SOF word (must be < 2**C_LW)
C_CW, 16, statistics counter width

Ports:
sys_clk  in  1  sole clock
sys_rst_n  in  1  asynchronous active-low reset
phyreset  in  1  synchronous flush, active high
fifo_empty  in  1  RX FIFO empty
fifo_rd_en  out  1  RX FIFO read strobe
fifo_do  in  C_DW+4  [C_DW+3]=sof, [C_DW+2]=eof, [C_DW+1:C_DW] reserved, [C_DW-1:0]=data; valid cycle after fifo_rd_en
rx_data  out  C_DW  stream data
rx_sof  out  1  first word of frame
rx_eof  out  1  last word of frame
rx_err  out  1  qualifies rx_eof: frame truncated or malformed
rx_valid  out  1  word present
rx_ready  in  1  consumer accepts when rx_valid & rx_ready
frame_len  out  C_LW  word count of last frame emitted; updates on accepted eof
frame_done  out  1  one-cycle pulse on accepted eof
frame_cnt  out  C_CW  frames completed (good or bad), wraps
err_cnt  out  C_CW  errors detected, saturates at all-ones

Behaviour:
- Reset (sys_rst_n low), async: fifo_rd_en=0, rx_valid=0, rx_data/sof/eof/err=0, frame_len=0, frame_done=0, counters=0, state IDLE, buffer empty, inflight=0.
- Credit rule: fifo_rd_en = !fifo_empty & !phyreset & (occupancy + inflight + pop_this_cycle... ) — precisely: (occ - pop + inflight) < 2, where pop = rx_valid & rx_ready. Never overflows the buffer; sustains 1 word/cycle with rx_ready held high.
- Latency: fifo_rd_en in cycle N -> word registered into buffer at end of N+1 -> rx_valid in N+2 (when buffer was empty).
- Buffer: 2-entry FIFO, in-order; rx_* driven from head; rx_* held stable while rx_valid & !rx_ready.
- Frame checker runs on each returned FIFO word (cycle N+1) before buffering. States IDLE, IN_FRAME, DROP; word counter wcnt.
- IDLE: sof=1 -> push word, wcnt=1; eof also set -> push with eof, stay IDLE, else -> IN_FRAME. sof=0 -> discard word, err_cnt++; eof also set -> stay IDLE.
- IN_FRAME, normal word: push, wcnt++; eof -> IDLE.
- IN_FRAME, sof=1: push word with eof=1, err=1 (terminates current frame), err_cnt++; source eof on the same word -> IDLE, else -> DROP.
- IN_FRAME, length limit: word with wcnt+1 == C_MAX_WORDS and eof=0 -> push with eof=1, err=1, err_cnt++, -> DROP. Limit reached with eof=1 -> normal good frame.
- DROP: discard words; eof -> IDLE. A sof word in DROP is also discarded (no extra error).
- Pushed bit-pairs: sof passes through; eof/err as above; reserved bits ignored.
- Output side: on accepted word with rx_eof: frame_done=1 next cycle, frame_len=output-side word count (1..C_MAX_WORDS), frame_cnt++. Output word count resets on accepted rx_sof.
- phyreset high: fifo_rd_en=0, buffer cleared, rx_valid=0, state IDLE, word counters cleared, in-flight returned word discarded; frame_cnt/err_cnt cleared; frame_len cleared. Takes effect next edge; lasts while held.
- Simultaneous push and pop on a full buffer: legal (credit rule guarantees space).
- Error and frame_done in the same cycle: both counters update independently.

Test Plan:
- Back-to-back: FIFO holds frames of 1, 3 and 2049 words, rx_ready=1 -> rx_valid continuous after 2-cycle start, frame_len 1, 3, 2049, frame_cnt=3, err_cnt=0, rx_err never set.
- Backpressure: 8-word frame, rx_ready toggling 1,0,0,1... -> no word lost or duplicated, data stable while stalled, fifo_rd_en never drives occupancy above 2.
- Orphan: word sof=0,eof=0 then valid 4-word frame -> orphan dropped, err_cnt=1, frame_len=4.
- SOF mid-frame: sof,d,d,sof,d,eof -> 4 words emitted, 4th has rx_eof=1 rx_err=1, last 2 dropped, err_cnt=1, frame_cnt=1.
- Overlength: 2100-word frame -> 2049 words emitted, last rx_eof=1 rx_err=1, remainder discarded, next frame good.
- Flush: phyreset for 3 cycles mid-frame with 2 words buffered -> rx_valid=0, counters=0, next frame starts cleanly from IDLE; async sys_rst_n pulse mid-frame gives same result.

Source files
------------

// File: rtl/rxll_frame_rd.sv
// Read-side controller for the link-layer RX FIFO: pulls words through a 2-entry prefetch buffer,
// enforces SOF/EOF pairing and maximum frame length, and keeps frame/error statistics.
module rxll_frame_rd #(
    parameter int unsigned C_DW        = 32,
    parameter int unsigned C_LW        = 12,
    parameter int unsigned C_MAX_WORDS = 2049,
    parameter int unsigned C_CW        = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            phyreset,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [C_DW+3:0] fifo_do,
    output logic [C_DW-1:0] rx_data,
    output logic            rx_sof,
    output logic            rx_eof,
    output logic            rx_err,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [C_LW-1:0] frame_len,
    output logic            frame_done,
    output logic [C_CW-1:0] frame_cnt,
    output logic [C_CW-1:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StInFrame, StDrop} state_e;

    localparam logic [C_LW-1:0] LimWords = C_LW'(C_MAX_WORDS - 1);

    state_e          state_q;
    logic [C_LW-1:0] wcnt_q;
    logic [C_LW-1:0] ocnt_q;
    logic            inflight_q;
    logic [C_DW+2:0] buf_q [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      occ_q;

    logic            w_sof;
    logic            w_eof;
    logic [C_DW-1:0] w_data;
    logic            unused_rsvd;
    logic            at_limit;
    logic            push;
    logic            push_eof;
    logic            push_err;
    logic            err_inc;
    logic            pop;
    logic [2:0]      credit;

    assign w_sof       = fifo_do[C_DW+3];
    assign w_eof       = fifo_do[C_DW+2];
    assign w_data      = fifo_do[C_DW-1:0];
    assign unused_rsvd = ^fifo_do[C_DW+1:C_DW];
    assign at_limit    = (wcnt_q == LimWords);

    assign rx_valid = (occ_q != 2'd0);
    assign {rx_sof, rx_eof, rx_err, rx_data} = buf_q[rd_ptr_q];
    assign pop = rx_valid & rx_ready;

    // Words already buffered or still in flight may never exceed the two buffer slots.
    assign credit     = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign fifo_rd_en = sys_rst_n & ~phyreset & ~fifo_empty & (credit < 3'd2);

    always_comb begin
        push     = 1'b0;
        push_eof = w_eof;
        push_err = 1'b0;
        err_inc  = 1'b0;
        if (inflight_q && !phyreset) begin
            unique case (state_q)
                StIdle: begin
                    if (w_sof) push = 1'b1;
                    else       err_inc = 1'b1;
                end
                StInFrame: begin
                    push = 1'b1;
                    if (w_sof || (at_limit && !w_eof)) begin
                        push_eof = 1'b1;
                        push_err = 1'b1;
                        err_inc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else if (phyreset) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else if (inflight_q) begin
            unique case (state_q)
                StIdle: begin
                    if (w_sof) begin
                        wcnt_q  <= C_LW'(1);
                        state_q <= w_eof ? StIdle : StInFrame;
                    end
                end
                StInFrame: begin
                    if (w_sof) begin
                        state_q <= w_eof ? StIdle : StDrop;
                    end else if (at_limit && !w_eof) begin
                        state_q <= StDrop;
                    end else begin
                        wcnt_q <= wcnt_q + C_LW'(1);
                        if (w_eof) state_q <= StIdle;
                    end
                end
                StDrop: begin
                    if (w_eof) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else if (phyreset) begin
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (push) begin
                buf_q[wr_ptr_q] <= {w_sof, push_eof, push_err, w_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ocnt_q     <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else if (phyreset) begin
            ocnt_q     <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            frame_done <= pop & rx_eof;
            if (pop) begin
                ocnt_q <= rx_sof ? C_LW'(1) : ocnt_q + C_LW'(1);
                if (rx_eof) begin
                    frame_len <= rx_sof ? C_LW'(1) : ocnt_q + C_LW'(1);
                    frame_cnt <= frame_cnt + C_CW'(1);
                end
            end
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + C_CW'(1);
        end
    end

endmodule

// File: tb/tb_rxll_frame_rd.sv
// Scoreboard bench for rxll_frame_rd: a queue-backed FIFO model feeds the DUT, expected stream
// words and frame lengths are queued by the stimulus and popped by an independent monitor.
module tb_rxll_frame_rd;

    localparam int unsigned DW   = 32;
    localparam int unsigned LW   = 12;
    localparam int unsigned MAXW = 2049;
    localparam int unsigned CW   = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          phyreset = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW+3:0] fifo_do = '0;
    logic [DW-1:0] rx_data;
    logic          rx_sof, rx_eof, rx_err, rx_valid;
    logic          rx_ready = 1'b1;
    logic [LW-1:0] frame_len;
    logic          frame_done;
    logic [CW-1:0] frame_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW+3:0] src[$];
    logic [DW+2:0] exp_q[$];
    int            exp_len[$];

    int            ready_mode = 0;
    bit            hold_en = 0;
    bit            gap_en = 0;
    bit            seen_valid = 0;
    int            gaps = 0;
    int            outst = 0;
    int            max_outst = 0;
    bit            stall_prev = 0;
    logic [DW+2:0] prev_word = '0;
    logic [DW+2:0] got;
    logic [DW+2:0] want;
    int            want_len;

    rxll_frame_rd #(
        .C_DW(DW), .C_LW(LW), .C_MAX_WORDS(MAXW), .C_CW(CW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .phyreset  (phyreset),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_do   (fifo_do),
        .rx_data   (rx_data),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_err    (rx_err),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_len (frame_len),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Standard FIFO model: one-cycle read latency.
    always @(posedge sys_clk) begin
        if (fifo_rd_en && src.size() > 0) fifo_do <= src.pop_front();
        fifo_empty <= (src.size() == 0);
        if (fifo_rd_en) outst++;
        if (rx_valid && rx_ready) outst--;
        if (outst > max_outst) max_outst = outst;
    end

    initial begin
        int ph = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b1;
                1:       begin rx_ready = (ph % 3 == 0); ph++; end
                default: rx_ready = 1'b0;
            endcase
        end
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            got = {rx_sof, rx_eof, rx_err, rx_data};
            if (hold_en && stall_prev) check("stall hold", {rx_valid, got}, {1'b1, prev_word});
            stall_prev = rx_valid && !rx_ready;
            prev_word  = got;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected word: got 0x%0h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    check("stream word", got, want);
                end
            end
            if (gap_en) begin
                if (rx_valid) seen_valid = 1;
                else if (seen_valid && exp_q.size() > 0) gaps++;
            end
            if (frame_done) begin
                if (exp_len.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected frame_done: got len %0d expected none", frame_len);
                end else begin
                    want_len = exp_len.pop_front();
                    if (want_len >= 0) check("frame_len", frame_len, want_len);
                end
            end
        end
    end

    task automatic src_word(input bit sof, input bit eof, input logic [DW-1:0] d);
        src.push_back({sof, eof, 2'b11, d});
    endtask

    task automatic good_frame(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            src_word(i == 0, i == n - 1, base + DW'(i));
            exp_q.push_back({i == 0, i == n - 1, 1'b0, base + DW'(i)});
        end
        exp_len.push_back(n);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || exp_len.size() != 0 || src.size() != 0) && k < 6000) begin
            @(posedge sys_clk);
            k++;
        end
        check({name, " drain in budget"}, k < 6000, 1);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset rx_valid", rx_valid, 0);
        check("reset fifo_rd_en", fifo_rd_en, 0);
        check("reset rx_word", {rx_sof, rx_eof, rx_err, rx_data}, 0);
        check("reset frame_len", frame_len, 0);
        check("reset frame_done", frame_done, 0);
        check("reset counters", {frame_cnt, err_cnt}, 0);
        #2 sys_rst_n = 1'b1;

        // Back-to-back frames, including one exactly at the length limit.
        gap_en = 1;
        good_frame(1, 32'h100);
        good_frame(3, 32'h200);
        good_frame(MAXW, 32'h1000_0000);
        drain("b2b");
        gap_en = 0;
        check("b2b stream gaps", gaps, 0);
        check("b2b frame_cnt", frame_cnt, 3);
        check("b2b err_cnt", err_cnt, 0);

        // Backpressure with ready pattern 1,0,0.
        outst = 0;
        max_outst = 0;
        hold_en = 1;
        ready_mode = 1;
        good_frame(8, 32'h3000);
        drain("bp");
        hold_en = 0;
        ready_mode = 0;
        check("bp outstanding <= 2", max_outst <= 2, 1);
        check("bp frame_cnt", frame_cnt, 4);

        // Orphan word ahead of a valid frame.
        src_word(0, 0, 32'hdead);
        good_frame(4, 32'h4000);
        drain("orphan");
        check("orphan err_cnt", err_cnt, 1);
        check("orphan frame_cnt", frame_cnt, 5);

        // SOF mid-frame: the 4th word terminates with err and carries its own sof through.
        src_word(1, 0, 32'h5000); exp_q.push_back({3'b100, 32'h5000});
        src_word(0, 0, 32'h5001); exp_q.push_back({3'b000, 32'h5001});
        src_word(0, 0, 32'h5002); exp_q.push_back({3'b000, 32'h5002});
        src_word(1, 0, 32'h5003); exp_q.push_back({3'b111, 32'h5003});
        src_word(0, 0, 32'h5004);
        src_word(0, 1, 32'h5005);
        exp_len.push_back(-1);
        good_frame(2, 32'h5100);
        drain("midsof");
        check("midsof err_cnt", err_cnt, 2);
        check("midsof frame_cnt", frame_cnt, 7);

        // Overlength: 2100 words, truncated at MAXW, then a good frame.
        for (int i = 0; i < 2100; i++) begin
            src_word(i == 0, i == 2099, 32'h6000_0000 + 32'(i));
            if (i < MAXW - 1) exp_q.push_back({i == 0, 2'b00, 32'h6000_0000 + 32'(i)});
            else if (i == MAXW - 1) exp_q.push_back({3'b011, 32'h6000_0000 + 32'(i)});
        end
        exp_len.push_back(MAXW);
        good_frame(2, 32'h7000);
        drain("overlen");
        check("overlen err_cnt", err_cnt, 3);
        check("overlen frame_cnt", frame_cnt, 9);

        // phyreset flush with two words buffered.
        ready_mode = 2;
        @(posedge sys_clk); #1;
        for (int i = 0; i < 6; i++) src_word(i == 0, 0, 32'h8800 + 32'(i));
        repeat (6) @(posedge sys_clk);
        #1;
        check("flush pre rx_valid", rx_valid, 1);
        phyreset = 1'b1;
        src.delete();
        @(posedge sys_clk); #1;
        check("flush rx_valid", rx_valid, 0);
        check("flush fifo_rd_en", fifo_rd_en, 0);
        check("flush counters", {frame_cnt, err_cnt}, 0);
        check("flush frame_len", frame_len, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        phyreset = 1'b0;
        ready_mode = 0;
        good_frame(3, 32'h8000);
        drain("flush");
        check("flush frame_cnt", frame_cnt, 1);
        check("flush err_cnt", err_cnt, 0);

        // Asynchronous reset mid-frame.
        ready_mode = 2;
        @(posedge sys_clk); #1;
        for (int i = 0; i < 6; i++) src_word(i == 0, 0, 32'h9900 + 32'(i));
        repeat (6) @(posedge sys_clk);
        #1;
        check("arst pre rx_valid", rx_valid, 1);
        #2 sys_rst_n = 1'b0;
        src.delete();
        #1;
        check("arst rx_valid", rx_valid, 0);
        check("arst fifo_rd_en", fifo_rd_en, 0);
        check("arst counters", {frame_cnt, err_cnt}, 0);
        check("arst frame_len", frame_len, 0);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        ready_mode = 0;
        good_frame(2, 32'h9000);
        drain("arst");
        check("arst frame_cnt", frame_cnt, 1);
        check("arst err_cnt", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
